output_arbiter: RTL and testbench

Round-robin scheduler that shares the single nibble-serialising output loader between N requesters (watchdog channels, status sources). Each requester posts a mode and a word pair; the arbiter grants one at a time, latches its payload, issues the loader start, tracks loader busy through the transfer, and returns a one-cycle completion acknowledge. A busy-watchdog aborts the wait if the loader never starts or never finishes.

---
 rtl/output_arbiter.sv | 124 ++++++++++++
 tb/tb_output_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_arbiter.sv
// Round-robin arbiter sharing one nibble-serialising output loader among N requesters.
// Latches the winner's payload, strobes the loader, tracks busy with a watchdog, and acks.
//
// state     | meaning
// IDLE      | no transfer; arbitrate when loader idle
// ISSUE     | ld_start high for the loader
// WAIT_BUSY | waiting for loader to raise busy
// WAIT_DONE | waiting for loader to drop busy
// DONE      | ack (and timeout if aborted) pulsed; back to IDLE
module output_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [N-1:0]           req,
    input  logic [3*N-1:0]         mode_in,
    input  logic [W*N-1:0]         wordA_in,
    input  logic [W*N-1:0]         wordB_in,
    output logic [N-1:0]           ack,
    output logic                   timeout,
    output logic [7:0]             err_count,
    output logic                   active,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   ld_start,
    output logic [2:0]             ld_mode,
    output logic [W-1:0]           ld_wordA,
    output logic [W-1:0]           ld_wordB,
    input  logic                   ld_busy
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   last_ptr;
    logic [CW-1:0]   wd_cnt;
    logic            found;
    logic [IW-1:0]   pick;
    int              sel;

    // First set request strictly after last_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sel   = 0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_ptr  <= IW'(N - 1);
            wd_cnt    <= '0;
            ack       <= '0;
            timeout   <= 1'b0;
            err_count <= 8'd0;
            active    <= 1'b0;
            grant_id  <= '0;
            ld_start  <= 1'b0;
            ld_mode   <= 3'd0;
            ld_wordA  <= '0;
            ld_wordB  <= '0;
        end else begin
            ack     <= '0;
            timeout <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (!ld_busy && found) begin
                            ld_mode  <= mode_in[3*sel +: 3];
                            ld_wordA <= wordA_in[W*sel +: W];
                            ld_wordB <= wordB_in[W*sel +: W];
                            grant_id <= pick;
                            last_ptr <= pick;
                            ld_start <= 1'b1;
                            active   <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        ld_start <= 1'b0;
                        wd_cnt   <= CW'(TIMEOUT - 1);
                        state    <= WAIT_BUSY;
                    end
                    WAIT_BUSY, WAIT_DONE: begin
                        // Watchdog spans both waits: down-counter, abort at terminal count.
                        if ((state == WAIT_BUSY) && ld_busy) begin
                            state <= WAIT_DONE;
                            wd_cnt <= wd_cnt - 1'b1;
                        end else if ((state == WAIT_DONE) && !ld_busy) begin
                            state         <= DONE;
                            ack[grant_id] <= 1'b1;
                        end else if (wd_cnt == '0) begin
                            state         <= DONE;
                            ack[grant_id] <= 1'b1;
                            timeout       <= 1'b1;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end else begin
                            wd_cnt <= wd_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: loader model plus a round-robin/timing
// reference computed from the arbitration rules.
module tb_output_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int TIMEOUT = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ena = 1'b1;
    logic [N-1:0]     req = '0;
    logic [3*N-1:0]   mode_in = '0;
    logic [W*N-1:0]   wordA_in = '0;
    logic [W*N-1:0]   wordB_in = '0;
    logic [N-1:0]     ack;
    logic             timeout;
    logic [7:0]       err_count;
    logic             active;
    logic [IW-1:0]    grant_id;
    logic             ld_start;
    logic [2:0]       ld_mode;
    logic [W-1:0]     ld_wordA;
    logic [W-1:0]     ld_wordB;
    logic             ld_busy;

    logic             force_busy = 1'b0;
    logic             no_busy = 1'b0;
    int               lcnt;

    int n_assert = 0;
    int n_fail = 0;
    int last_m = N - 1;
    int err_m = 0;
    logic [2:0]   mode_m [N];
    logic [W-1:0] wa_m [N];
    logic [W-1:0] wb_m [N];

    output_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
        .mode_in(mode_in), .wordA_in(wordA_in), .wordB_in(wordB_in),
        .ack(ack), .timeout(timeout), .err_count(err_count), .active(active),
        .grant_id(grant_id), .ld_start(ld_start), .ld_mode(ld_mode),
        .ld_wordA(ld_wordA), .ld_wordB(ld_wordB), .ld_busy(ld_busy)
    );

    always #5 clk = ~clk;

    // 16-nibble loader: busy for 16 enabled cycles after seeing a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lcnt <= 0;
        else if (ena) begin
            if (ld_start && lcnt == 0 && !no_busy) lcnt <= 16;
            else if (lcnt != 0) lcnt <= lcnt - 1;
        end
    end
    assign ld_busy = force_busy | (lcnt != 0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            mode_in[3*i +: 3]  = mode_m[i];
            wordA_in[W*i +: W] = wa_m[i];
            wordB_in[W*i +: W] = wb_m[i];
        end
    endtask

    task automatic new_payload();
        for (int i = 0; i < N; i++) begin
            mode_m[i] = 3'($urandom);
            wa_m[i]   = $urandom;
            wb_m[i]   = $urandom;
        end
        pack();
    endtask

    task automatic step(input bit tog);
        @(negedge clk);
        if (tog) ena = ~ena;
    endtask

    task automatic do_slot(input int exp_lat, input bit exp_to, input bit tog,
                           input int bound, output int gwait);
        int exp_id, w, lat, starts;
        logic [2:0] sm;
        logic [W-1:0] sa, sb;
        logic prev;
        exp_id = rr_pick(req, last_m);
        if (exp_id < 0) exp_id = 0;
        w = 0;
        while (active !== 1'b1 && w < bound) begin
            step(tog);
            w++;
        end
        gwait = w;
        chk("grant_seen", 64'(active), 64'd1);
        if (active !== 1'b1) return;
        sm = mode_m[exp_id];
        sa = wa_m[exp_id];
        sb = wb_m[exp_id];
        chk("grant_id", 64'(grant_id), 64'(exp_id));
        chk("ld_mode", 64'(ld_mode), 64'(sm));
        chk("ld_wordA", 64'(ld_wordA), 64'(sa));
        chk("ld_wordB", 64'(ld_wordB), 64'(sb));
        chk("ld_start_at_grant", 64'(ld_start), 64'd1);
        last_m = exp_id;
        new_payload();
        starts = 1;
        prev = 1'b1;
        lat = 0;
        while (ack === '0 && lat < 200) begin
            step(tog);
            lat++;
            if (ld_start === 1'b1 && prev !== 1'b1) starts++;
            prev = ld_start;
        end
        if (exp_to) err_m = (err_m < 255) ? err_m + 1 : 255;
        chk("ack_onehot", 64'(ack), 64'(1) << exp_id);
        chk("timeout_flag", 64'(timeout), 64'(exp_to));
        chk("ack_latency", 64'(lat), 64'(exp_lat));
        chk("start_pulses", 64'(starts), 64'd1);
        chk("ld_mode_hold", 64'(ld_mode), 64'(sm));
        chk("ld_wordA_hold", 64'(ld_wordA), 64'(sa));
        chk("ld_wordB_hold", 64'(ld_wordB), 64'(sb));
        chk("err_count", 64'(err_count), 64'(err_m));
        req[exp_id] = 1'b0;
        step(tog);
        chk("ack_width", 64'(ack), 64'd0);
        chk("timeout_width", 64'(timeout), 64'd0);
        if (!tog) chk("idle_return", 64'(active), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int gw, r, w;
        new_payload();
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_ld_start", 64'(ld_start), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_ld_mode", 64'(ld_mode), 64'd0);
        chk("rst_ld_wordA", 64'(ld_wordA), 64'd0);
        chk("rst_ld_wordB", 64'(ld_wordB), 64'd0);
        rst_n = 1'b1;
        step(0);

        // directed single request on requester 2
        mode_m[2] = 3'd5;
        wa_m[2] = 32'h12345678;
        wb_m[2] = 32'h9ABCDEF0;
        pack();
        req = 4'b0100;
        do_slot(18, 1'b0, 1'b0, 10, gw);

        // all requesting, each drops on ack
        req = 4'b1111;
        for (int i = 0; i < N; i++) do_slot(18, 1'b0, 1'b0, 10, gw);
        chk("rotation_drained", 64'(req), 64'd0);

        // random request patterns
        for (int i = 0; i < 8; i++) begin
            req = req | 4'($urandom_range(0, 15));
            if (req == '0) req = 4'($urandom_range(1, 15));
            do_slot(18, 1'b0, 1'b0, 10, gw);
        end
        req = '0;
        repeat (2) step(0);

        // loader never goes busy: watchdog abort, then normal service
        r = $urandom_range(0, N - 1);
        req = N'(1) << r;
        no_busy = 1'b1;
        do_slot(TIMEOUT + 1, 1'b1, 1'b0, 10, gw);
        no_busy = 1'b0;
        req = N'(1) << ((r + 1) % N);
        do_slot(18, 1'b0, 1'b0, 10, gw);

        // ena toggling every cycle: half rate
        req = N'(1) << $urandom_range(0, N - 1);
        do_slot(36, 1'b0, 1'b1, 10, gw);
        ena = 1'b1;
        repeat (3) step(0);
        chk("toggle_idle", 64'(active), 64'd0);

        // loader busy while idle blocks the grant
        force_busy = 1'b1;
        req = 4'b0010;
        repeat (5) step(0);
        chk("busy_blocks_grant", 64'(active), 64'd0);
        force_busy = 1'b0;
        do_slot(18, 1'b0, 1'b0, 5, gw);
        chk("grant_after_busy", 64'(gw), 64'd1);

        // reset in the middle of WAIT_DONE
        new_payload();
        req = 4'b0100;
        w = 0;
        while (active !== 1'b1 && w < 10) begin
            step(0);
            w++;
        end
        chk("rst_test_grant", 64'(active), 64'd1);
        repeat (10) step(0);
        chk("rst_test_loader_busy", 64'(ld_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_active", 64'(active), 64'd0);
        chk("midrst_ld_start", 64'(ld_start), 64'd0);
        chk("midrst_ld_mode", 64'(ld_mode), 64'd0);
        chk("midrst_ld_wordA", 64'(ld_wordA), 64'd0);
        chk("midrst_ld_wordB", 64'(ld_wordB), 64'd0);
        chk("midrst_grant_id", 64'(grant_id), 64'd0);
        chk("midrst_err", 64'(err_count), 64'd0);
        last_m = N - 1;
        err_m = 0;
        req = 4'b1001;
        step(0);
        chk("midrst_no_ack", 64'(ack), 64'd0);
        chk("midrst_no_timeout", 64'(timeout), 64'd0);
        rst_n = 1'b1;
        do_slot(18, 1'b0, 1'b0, 10, gw);
        req = '0;
        repeat (3) step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
